// File: rtl/serial_fsub_if.sv
// rtl/serial_fsub_if.sv - start/busy/done operand and result bundle for serial_fsub
interface serial_fsub_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf
  );
endinterface

// File: rtl/serial_fsub.sv
// rtl/serial_fsub.sv - bit-serial W-bit subtractor d = a - b - bin, LSB first, one bit per clock
// Optional signed-overflow flag built when SERIAL_FSUB_OVF_EN is defined; otherwise ovf is tied to 0.
module serial_fsub #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_fsub_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  sr_q, sr_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          bout_q, bout_d;

  logic          diff;
  logic          borrow;
  logic [W-1:0]  sr_next;

  assign diff    = sa_q[0] ^ sb_q[0] ^ br_q;
  assign borrow  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign sr_next = {diff, sr_q[W-1:1]};

`ifdef SERIAL_FSUB_OVF_EN
  // {a_msb, b_msb} of the captured operands, needed once the last bit is out
  logic [1:0] msb_q, msb_d;
  logic       ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    bout_d  = bout_q;
`ifdef SERIAL_FSUB_OVF_EN
    msb_d   = msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
`ifdef SERIAL_FSUB_OVF_EN
          msb_d   = {bus.a[W-1], bus.b[W-1]};
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = sr_next;
        br_d  = borrow;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          res_d   = sr_next;
          bout_d  = borrow;
`ifdef SERIAL_FSUB_OVF_EN
          ovf_d   = (msb_q[1] != msb_q[0]) & (diff != msb_q[1]);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_FSUB_OVF_EN
      msb_q   <= 2'b00;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
`ifdef SERIAL_FSUB_OVF_EN
      msb_q   <= msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.d    = res_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_FSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`else
  assign bus.ovf  = 1'b0;
`endif
endmodule
